// File: rtl/posit_round_arbiter.sv
// posit_round_arbiter: two-requester round-robin front end feeding one shared
// posit round-to-nearest-even pipeline (S1 operand capture, S2 rounded result).
module posit_round_arbiter #(
  parameter int WIDTH = 8,
  parameter int ES = 1,
  parameter int TRAILING_BITS = 2
) (
  input  logic                                clock,
  input  logic                                resetN,
  input  logic [1:0]                          inValid,
  output logic [1:0]                          inReady,
  input  logic [1:0][WIDTH-1:0]               inPosit,
  input  logic [1:0][TRAILING_BITS-1:0]       inTrailing,
  input  logic [1:0]                          inSticky,
  output logic                                outValid,
  input  logic                                outReady,
  output logic [WIDTH-1:0]                    outPosit,
  output logic                                outId,
  output logic [1:0]                          inFlight
);
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d, ptr_q, ptr_d;
  logic s1_id_q, s2_id_q, s1_sticky_q;
  logic [WIDTH-1:0] s1_posit_q, s2_posit_q, round_d;
  logic [TRAILING_BITS-1:0] s1_trail_q;
  logic [1:0] gnt;
  logic adv, xfer, sel;
  logic sign, special, sat, up;
  logic [WIDTH-1:0] mag, rmag;
  logic [TRAILING_BITS:0] ext;
  // Posit encodings are monotonic in their bit string, so rounding the magnitude
  // pattern is exact for every exponent width.
  logic unused_es;
  assign unused_es = ES[0];
  always_comb begin
    adv = s1_v_q && (!s2_v_q || outReady);
    gnt[0] = inValid[0] && (!inValid[1] || !ptr_q);
    gnt[1] = inValid[1] && (!inValid[0] || ptr_q);
    inReady = (resetN && (!s1_v_q || adv)) ? gnt : 2'b00;
    xfer = |inReady;
    sel = inReady[1];
    ptr_d = xfer ? !sel : ptr_q;
    s1_v_d = xfer || (s1_v_q && !adv);
    s2_v_d = adv || (s2_v_q && !outReady);
  end
  // Decode to sign/magnitude, round the magnitude, re-encode; zero and NaR bypass.
  always_comb begin
    sign = s1_posit_q[WIDTH-1];
    mag = sign ? -s1_posit_q : s1_posit_q;
    special = ~|s1_posit_q[WIDTH-2:0];
    ext = {s1_trail_q, s1_sticky_q};
    up = ext[TRAILING_BITS] && ((|ext[TRAILING_BITS-1:0]) || mag[0]);
    sat = &mag[WIDTH-2:0];
    rmag = mag + WIDTH'(up && !sat);
    round_d = special ? s1_posit_q : (sign ? -rmag : rmag);
  end
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      ptr_q <= 1'b0;
      s1_id_q <= 1'b0;
      s1_posit_q <= '0;
      s1_trail_q <= '0;
      s1_sticky_q <= 1'b0;
      s2_id_q <= 1'b0;
      s2_posit_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      ptr_q <= ptr_d;
      if (xfer) begin
        s1_posit_q <= inPosit[sel];
        s1_trail_q <= inTrailing[sel];
        s1_sticky_q <= inSticky[sel];
        s1_id_q <= sel;
      end
      if (adv) begin
        s2_posit_q <= round_d;
        s2_id_q <= s1_id_q;
      end
    end
  end
  assign outValid = s2_v_q;
  assign outPosit = s2_posit_q;
  assign outId = s2_id_q;
  assign inFlight = {1'b0, s1_v_q} + {1'b0, s2_v_q};
endmodule

// File: tb/tb_posit_round_arbiter.sv
// tb_posit_round_arbiter: scoreboard bench for the posit rounding arbiter.
module tb_posit_round_arbiter;
  localparam int W = 8;
  localparam int TB = 2;
  logic clock = 1'b0;
  logic resetN = 1'b0;
  logic outReady = 1'b0;
  logic outValid, outId;
  logic [1:0] inValid = 2'b00;
  logic [1:0] inSticky = 2'b00;
  logic [1:0] inReady, inFlight;
  logic [1:0][W-1:0] inPosit = '0;
  logic [1:0][TB-1:0] inTrailing = '0;
  logic [W-1:0] outPosit;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  bit lat_chk = 1'b1;
  typedef struct {logic id; logic [W-1:0] p; int c;} exp_t;
  exp_t q[$];

  posit_round_arbiter #(.WIDTH(W), .ES(1), .TRAILING_BITS(TB)) dut (
    .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady),
    .inPosit(inPosit), .inTrailing(inTrailing), .inSticky(inSticky),
    .outValid(outValid), .outReady(outReady), .outPosit(outPosit),
    .outId(outId), .inFlight(inFlight));

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic logic [W-1:0] ref_round(logic [W-1:0] p, logic [TB-1:0] t, logic s);
    int m, r;
    if (p[W-2:0] == '0) return p;
    m = p[W-1] ? (1 << W) - int'(p) : int'(p);
    r = int'({t, s});
    if (r > (1 << TB) || (r == (1 << TB) && (m % 2) == 1)) m = m + 1;
    if (m > (1 << (W - 1)) - 1) m = (1 << (W - 1)) - 1;
    return p[W-1] ? W'((1 << W) - m) : W'(m);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin : push
    exp_t n;
    if (resetN)
      for (int r = 0; r < 2; r++)
        if (inValid[r] && inReady[r]) begin
          n.id = r[0];
          n.p = ref_round(inPosit[r], inTrailing[r], inSticky[r]);
          n.c = cyc;
          q.push_back(n);
        end
  end

  always @(negedge clock) begin : mon
    exp_t e;
    if (resetN && outValid && outReady) begin
      if (q.size() == 0) chk("spurious_out", {31'b0, outValid}, 0);
      else begin
        e = q.pop_front();
        chk("sb_posit", {24'b0, outPosit}, {24'b0, e.p});
        chk("sb_id", {31'b0, outId}, {31'b0, e.id});
        if (lat_chk) chk("sb_latency", cyc - e.c, 2);
      end
    end
  end

  always @(negedge resetN) q.delete();

  task automatic send(int r, logic [W-1:0] p, logic [TB-1:0] t, logic s);
    int n = 0;
    inValid[r] = 1'b1;
    inPosit[r] = p;
    inTrailing[r] = t;
    inSticky[r] = s;
    @(negedge clock);
    while (!inReady[r] && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n == 20) chk("send_ready", {31'b0, inReady[r]}, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic one(int r, logic [W-1:0] p, logic [TB-1:0] t, logic s, logic [W-1:0] x);
    send(r, p, t, s);
    inValid[r] = 1'b0;
    @(negedge clock);
    chk("vec_s1_novalid", {31'b0, outValid}, 0);
    @(negedge clock);
    chk("vec_valid", {31'b0, outValid}, 1);
    chk("vec_posit", {24'b0, outPosit}, {24'b0, x});
    chk("vec_id", {31'b0, outId}, r);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetN = 1'b0;
    inValid = 2'b00;
    @(posedge clock);
    #1 resetN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] hold_p;
    logic hold_id;
    repeat (3) @(posedge clock);
    #1 inValid = 2'b11;
    #1;
    chk("rst_outValid", {31'b0, outValid}, 0);
    chk("rst_inReady", {30'b0, inReady}, 0);
    chk("rst_inFlight", {30'b0, inFlight}, 0);
    chk("rst_outPosit", {24'b0, outPosit}, 0);
    chk("rst_outId", {31'b0, outId}, 0);
    inValid = 2'b00;
    @(posedge clock);
    #1 resetN = 1'b1;
    outReady = 1'b1;
    inValid[0] = 1'b1;
    inPosit[0] = 8'h41;
    inTrailing[0] = 2'b10;
    inSticky[0] = 1'b0;
    @(negedge clock);
    chk("first_accept", {30'b0, inReady}, 2'b01);
    @(posedge clock);
    #1 inValid[0] = 1'b0;
    @(negedge clock);
    chk("lat_s1_novalid", {31'b0, outValid}, 0);
    @(negedge clock);
    chk("tie_valid", {31'b0, outValid}, 1);
    chk("tie_posit", {24'b0, outPosit}, 8'h42);
    chk("tie_id", {31'b0, outId}, 0);
    @(posedge clock);
    #1;
    one(0, 8'h00, 2'b11, 1'b1, 8'h00);
    one(0, 8'h80, 2'b11, 1'b1, 8'h80);
    one(0, 8'h7F, 2'b11, 1'b1, 8'h7F);
    one(0, 8'h01, 2'b00, 1'b0, 8'h01);
    one(0, 8'h43, 2'b10, 1'b0, 8'h44);
    one(0, 8'h42, 2'b10, 1'b0, 8'h42);
    one(1, 8'h42, 2'b10, 1'b1, 8'h43);
    one(1, 8'h42, 2'b01, 1'b1, 8'h42);
    one(1, 8'h42, 2'b11, 1'b0, 8'h43);

    do_reset();
    inValid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      inPosit[0] = W'(8'h10 + i);
      inPosit[1] = W'(8'h50 + 3 * i);
      inTrailing[0] = TB'(i);
      inTrailing[1] = TB'(3 - i);
      inSticky = 2'(i);
      @(negedge clock);
      chk("rr_grant", {30'b0, inReady}, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i >= 2) begin
        chk("rr_throughput", {31'b0, outValid}, 1);
        chk("rr_outId", {31'b0, outId}, i % 2);
      end
      @(posedge clock);
      #1;
    end

    lat_chk = 1'b0;
    outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i == 0) begin
        hold_p = outPosit;
        hold_id = outId;
      end
      chk("stall_valid", {31'b0, outValid}, 1);
      chk("stall_posit", {24'b0, outPosit}, {24'b0, hold_p});
      chk("stall_id", {31'b0, outId}, {31'b0, hold_id});
      chk("stall_inFlight", {30'b0, inFlight}, 2);
      chk("stall_inReady", {30'b0, inReady}, 0);
      @(posedge clock);
      #1;
    end
    outReady = 1'b1;
    inValid = 2'b00;
    repeat (4) @(negedge clock);
    chk("stall_drained", q.size(), 0);
    lat_chk = 1'b1;

    @(posedge clock);
    #1 outReady = 1'b0;
    inValid = 2'b01;
    inPosit[0] = 8'h33;
    repeat (2) @(posedge clock);
    #1 inValid = 2'b11;
    chk("pre_rst_inFlight", {30'b0, inFlight}, 2);
    @(negedge clock);
    #1 resetN = 1'b0;
    #1;
    chk("async_rst_outValid", {31'b0, outValid}, 0);
    chk("async_rst_inFlight", {30'b0, inFlight}, 0);
    chk("async_rst_inReady", {30'b0, inReady}, 0);
    chk("async_rst_outPosit", {24'b0, outPosit}, 0);
    @(posedge clock);
    #1 resetN = 1'b1;
    inValid = 2'b00;
    outReady = 1'b1;
    repeat (4) begin
      @(negedge clock);
      chk("no_stale", {31'b0, outValid}, 0);
    end
    @(posedge clock);
    #1 inValid = 2'b11;
    @(negedge clock);
    chk("ptr_after_rst", {30'b0, inReady}, 2'b01);
    @(posedge clock);
    #1 inValid = 2'b00;
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1;

    for (int p = 0; p < (1 << W); p++)
      for (int t = 0; t < (1 << TB); t++)
        for (int s = 0; s < 2; s++) begin
          inPosit[0] = W'($urandom);
          send(1, W'(p), TB'(t), s[0]);
        end
    inValid = 2'b00;
    repeat (4) @(negedge clock);
    chk("sweep_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
